// File: rtl/box_painter_if.sv
// Painter handshake: request strobe/busy/done plus the valid/ready pixel write stream.
interface box_painter_if #(
    parameter int unsigned COLOR_W = 9
);
    logic               start;
    logic [9:0]         x0;
    logic [8:0]         y0;
    logic [COLOR_W-1:0] color;
    logic               busy;
    logic               done;
    logic [9:0]         pix_x;
    logic [8:0]         pix_y;
    logic [COLOR_W-1:0] pix_color;
    logic               pix_write;
    logic               pix_ready;

    modport slave (
        input  start, x0, y0, color, pix_ready,
        output busy, done, pix_x, pix_y, pix_color, pix_write
    );

    modport master (
        output start, x0, y0, color, pix_ready,
        input  busy, done, pix_x, pix_y, pix_color, pix_write
    );
endinterface

// File: rtl/box_painter.sv
// Rasterises a BOX_W x BOX_H filled box one pixel per cycle onto a valid/ready pixel port,
// clipping pixels that fall off the right or bottom screen edge.
module box_painter #(
    parameter int unsigned BOX_W    = 64,
    parameter int unsigned BOX_H    = 24,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned COLOR_W  = 9
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    box_painter_if.slave    pnt
);
    localparam int unsigned X_W  = 10;
    localparam int unsigned Y_W  = 9;
    localparam int unsigned SX_W = X_W + 1;
    localparam int unsigned SY_W = Y_W + 1;
    localparam int unsigned CX_W = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int unsigned CY_W = (BOX_H > 1) ? $clog2(BOX_H) : 1;

    typedef enum logic [1:0] {IDLE, PAINT, FIN} state_e;

    state_e             state_q, state_d;
    logic [X_W-1:0]     bx_q, bx_d;
    logic [Y_W-1:0]     by_q, by_d;
    logic [COLOR_W-1:0] col_q, col_d;
    logic [CX_W-1:0]    cx_q, cx_d;
    logic [CY_W-1:0]    cy_q, cy_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [X_W-1:0]     pix_x_q, pix_x_d;
    logic [Y_W-1:0]     pix_y_q, pix_y_d;
    logic [COLOR_W-1:0] pix_color_q, pix_color_d;
    logic               pix_write_q, pix_write_d;
    logic               adv;
    logic [SX_W-1:0]    sx;
    logic [SY_W-1:0]    sy;

    // Next state, counters, and the pixel presented for the next-cycle counter values.
    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        col_d   = col_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        adv     = 1'b0;

        case (state_q)
            IDLE, FIN: begin
                if (pnt.start) begin
                    state_d = PAINT;
                    bx_d    = pnt.x0;
                    by_d    = pnt.y0;
                    col_d   = pnt.color;
                    cx_d    = '0;
                    cy_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            PAINT: begin
                // A clipped pixel is never offered, so it steps on without waiting for ready.
                adv = pix_write_q ? pnt.pix_ready : 1'b1;
                if (adv) begin
                    if (cx_q == CX_W'(BOX_W - 1)) begin
                        cx_d = '0;
                        if (cy_q == CY_W'(BOX_H - 1)) begin
                            cy_d    = '0;
                            state_d = FIN;
                        end else begin
                            cy_d = cy_q + CY_W'(1);
                        end
                    end else begin
                        cx_d = cx_q + CX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        sx = {1'b0, bx_d} + SX_W'(cx_d);
        sy = {1'b0, by_d} + SY_W'(cy_d);

        busy_d      = (state_d == PAINT);
        done_d      = (state_d == FIN);
        pix_write_d = (state_d == PAINT) && (sx < SX_W'(SCREEN_W)) && (sy < SY_W'(SCREEN_H));
        pix_x_d     = (state_d == PAINT) ? sx[X_W-1:0] : pix_x_q;
        pix_y_d     = (state_d == PAINT) ? sy[Y_W-1:0] : pix_y_q;
        pix_color_d = (state_d == PAINT) ? col_d       : pix_color_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            bx_q        <= '0;
            by_q        <= '0;
            col_q       <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_color_q <= '0;
            pix_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            col_q       <= col_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_color_q <= pix_color_d;
            pix_write_q <= pix_write_d;
        end
    end

    assign pnt.busy      = busy_q;
    assign pnt.done      = done_q;
    assign pnt.pix_x     = pix_x_q;
    assign pnt.pix_y     = pix_y_q;
    assign pnt.pix_color = pix_color_q;
    assign pnt.pix_write = pix_write_q;
endmodule

// File: tb/tb_box_painter.sv
// Directed bench for box_painter: raster order, clipping, stalls, start filtering and reset abort.
module tb_box_painter;
    logic clk;
    logic reset;

    box_painter_if #(.COLOR_W(9)) bus ();

    box_painter #(
        .BOX_W(64), .BOX_H(24), .SCREEN_W(640), .SCREEN_H(480), .COLOR_W(9)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .pnt      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          nwr, busy_cyc, done_cyc, done_cnt, seq_err, stall_err, outside, stalls, last_acc;
    bit          timeout, aborted;
    logic [27:0] first_px, last_px;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one box, scoring every accepted pixel against a raster/clip model of the request.
    task automatic paint(input logic [9:0] x, input logic [8:0] y, input logic [8:0] c,
                         input bit rnd, input int inject, input bit chain,
                         input logic [9:0] nx, input logic [8:0] ny, input logic [8:0] nc,
                         input bit pre, input int abort_n);
        logic [27:0] expq[$];
        logic [27:0] got, saved;
        bit          stall_prev, rdy;
        int          cyc;
        for (int j = 0; j < 24; j++)
            for (int i = 0; i < 64; i++)
                if (int'(x) + i < 640 && int'(y) + j < 480)
                    expq.push_back({10'(int'(x) + i), 9'(int'(y) + j), c});
        nwr = 0; busy_cyc = 0; done_cyc = 0; done_cnt = 0; seq_err = 0; stall_err = 0;
        outside = 0; stalls = 0; last_acc = 0; timeout = 0; aborted = 0;
        first_px = '0; last_px = '0; saved = '0; stall_prev = 0;
        if (!pre) begin
            bus.x0 = x; bus.y0 = y; bus.color = c; bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        cyc = 1;
        while (1) begin
            if (cyc > 5000) begin timeout = 1; break; end
            bus.start = 1'b0;
            if (abort_n > 0 && nwr == abort_n) begin aborted = 1; break; end
            got = {bus.pix_x, bus.pix_y, bus.pix_color};
            if (bus.busy) busy_cyc++;
            if (stall_prev && (got !== saved || bus.pix_write !== 1'b1)) stall_err++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (bus.pix_write && (bus.pix_x >= 10'd640 || bus.pix_y >= 9'd480)) outside++;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.pix_ready = rdy;
            if (bus.pix_write) begin
                if (rdy) begin
                    if (expq.size() == 0) seq_err++;
                    else if (expq.pop_front() !== got) seq_err++;
                    if (nwr == 0) first_px = got;
                    last_px  = got;
                    last_acc = cyc;
                    nwr++;
                end else begin
                    stalls++;
                end
            end
            stall_prev = bus.pix_write && !rdy;
            saved      = got;
            if (cyc == inject) begin
                bus.start = 1'b1; bus.x0 = 10'd300; bus.y0 = 9'd200; bus.color = 9'h155;
            end
            if (bus.done && chain) begin
                bus.start = 1'b1; bus.x0 = nx; bus.y0 = ny; bus.color = nc;
                tick();
                bus.start = 1'b0;
                break;
            end
            if (done_cyc != 0 && cyc >= done_cyc + 3) break;
            tick();
            cyc++;
        end
        if (!aborted) seq_err += expq.size();
    endtask

    initial begin
        int dcount;
        reset = 1'b1;
        bus.start = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.color = '0; bus.pix_ready = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_write", 32'(bus.pix_write), 0);
        chk("rst_pix", {bus.pix_x, bus.pix_y, bus.pix_color}, 0);
        reset = 1'b0;
        tick();

        // Origin box, ready held high.
        paint(10'd0, 9'd0, 9'h1C7, 0, 0, 0, '0, '0, '0, 0, 0);
        chk("s1_timeout", 32'(timeout), 0);
        chk("s1_writes", nwr, 1536);
        chk("s1_first", first_px, {10'd0, 9'd0, 9'h1C7});
        chk("s1_last", last_px, {10'd63, 9'd23, 9'h1C7});
        chk("s1_seq", seq_err, 0);
        chk("s1_busy", busy_cyc, 1536);
        chk("s1_done_cyc", done_cyc, 1537);
        chk("s1_done_cnt", done_cnt, 1);

        // Box touching the bottom-right corner exactly.
        paint(10'd576, 9'd456, 9'h0F0, 0, 0, 0, '0, '0, '0, 0, 0);
        chk("s2_writes", nwr, 1536);
        chk("s2_last", last_px, {10'd639, 9'd479, 9'h0F0});
        chk("s2_outside", outside, 0);
        chk("s2_done_cyc", done_cyc, 1537);

        // Partially clipped box.
        paint(10'd600, 9'd468, 9'h03F, 0, 0, 0, '0, '0, '0, 0, 0);
        chk("s3_writes", nwr, 480);
        chk("s3_first", first_px, {10'd600, 9'd468, 9'h03F});
        chk("s3_last", last_px, {10'd639, 9'd479, 9'h03F});
        chk("s3_outside", outside, 0);
        chk("s3_seq", seq_err, 0);
        chk("s3_busy", busy_cyc, 1536);
        chk("s3_done_cyc", done_cyc, 1537);

        // Random back-pressure.
        paint(10'd0, 9'd0, 9'h1C7, 1, 0, 0, '0, '0, '0, 0, 0);
        chk("s4_timeout", 32'(timeout), 0);
        chk("s4_writes", nwr, 1536);
        chk("s4_seq", seq_err, 0);
        chk("s4_stable", stall_err, 0);
        chk("s4_done_after_last", done_cyc, last_acc + 1);
        chk("s4_busy", busy_cyc, 1536 + stalls);
        chk("s4_done_cnt", done_cnt, 1);
        bus.pix_ready = 1'b1;

        // Mid-box start ignored, then start in the done cycle chains a new box.
        paint(10'd50, 9'd60, 9'h03C, 0, 200, 1, 10'd100, 9'd50, 9'h0AB, 0, 0);
        chk("s5_writes", nwr, 1536);
        chk("s5_seq", seq_err, 0);
        chk("s5_done_cyc", done_cyc, 1537);
        chk("s5_chain_busy", 32'(bus.busy), 1);
        chk("s5_chain_done", 32'(bus.done), 0);
        chk("s5_chain_write", 32'(bus.pix_write), 1);
        chk("s5_chain_pix", {bus.pix_x, bus.pix_y, bus.pix_color}, {10'd100, 9'd50, 9'h0AB});
        paint(10'd100, 9'd50, 9'h0AB, 0, 0, 0, '0, '0, '0, 1, 0);
        chk("s5b_writes", nwr, 1536);
        chk("s5b_seq", seq_err, 0);
        chk("s5b_done_cyc", done_cyc, 1537);

        // Reset wins over a simultaneous start.
        reset = 1'b1; bus.start = 1'b1; bus.x0 = 10'd5; bus.y0 = 9'd5;
        tick();
        chk("rs_busy", 32'(bus.busy), 0);
        reset = 1'b0; bus.start = 1'b0;
        tick();
        chk("rs_busy_after", 32'(bus.busy), 0);
        chk("rs_write_after", 32'(bus.pix_write), 0);

        // Reset mid-box after 100 accepted pixels.
        paint(10'd10, 9'd10, 9'h111, 0, 0, 0, '0, '0, '0, 0, 100);
        chk("s6_aborted", 32'(aborted), 1);
        chk("s6_accepted", nwr, 100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s6_busy", 32'(bus.busy), 0);
        chk("s6_done", 32'(bus.done), 0);
        chk("s6_write", 32'(bus.pix_write), 0);
        dcount = 0;
        for (int k = 0; k < 1700; k++) begin
            if (bus.done || bus.busy) dcount++;
            tick();
        end
        chk("s6_quiet", dcount, 0);
        paint(10'd10, 9'd10, 9'h111, 0, 0, 0, '0, '0, '0, 0, 0);
        chk("s6_new_writes", nwr, 1536);
        chk("s6_new_seq", seq_err, 0);
        chk("s6_new_done_cyc", done_cyc, 1537);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
